recv_mailbox_arb: RTL
=====================

# recv_mailbox_arb

Round-robin receive mailbox between two 32-bit packet producers (ReCOP cores / NoC ports) and the Nios receive PIO path. Producers push words into a shared circular buffer; the Nios peeks and pops entries through its 8-bit `recv_addr` PIO and reads results on its 32-bit `recv_data` PIO. `pk_pending` drives the Nios `pk_input` PIO as a non-empty flag.

## Interface
- `DEPTH`, 16: buffer entries; power of two, 2..64.
- `clk_clk` in 1: system clock; all logic on rising edge.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: producer 0 has a word.
- `req0_data` in 32: producer 0 word.
- `req0_ready` out 1: producer 0 word accepted this cycle (valid & ready).
- `req1_valid` in 1: producer 1 has a word.
- `req1_data` in 32: producer 1 word.
- `req1_ready` out 1: producer 1 word accepted this cycle.
- `recv_addr` in 8: from Nios PIO; [7] pop toggle, [6:0] peek offset / status select.
- `recv_data` out 32: to Nios PIO; registered read result.
- `pk_pending` out 1: to Nios `pk_input`; registered, 1 when buffer non-empty.

## Operation
- Storage: DEPTH x 32 array, head pointer, tail pointer, count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Arbitration (combinational grant, registered `last`):
  - only one valid -> grant it; both valid -> grant the requester not equal to `last`; none -> no grant.
  - `reqN_ready` = granted & !full. On accept: write data at tail, tail+1, `last` <= N.
  - At most one push per cycle; losing producer holds valid/data (standard valid/ready; data must be stable while valid & !ready).
- Pop: `recv_addr[7]` is sampled into `pop_q` each cycle; a pop request is `recv_addr[7] != pop_q` (either edge).
  - non-empty: head+1, count-1.
  - empty: no pointer change; set sticky `underflow`.
- Simultaneous push and pop: both take effect, count unchanged. Push when full is impossible (ready low) even if a pop occurs the same cycle; the pop frees the slot for the next cycle.
- Read mux (registered into `recv_data` each cycle):
  - `recv_addr[6:0]` == 7'h7F -> status: [31] underflow, [30] full, [29] empty, [28:8] 0, [7:0] count (zero-extended).
  - offset < count -> mem[(head+offset) mod DEPTH].
  - otherwise -> 32'h0000_0000.
  - Mux uses state before the current cycle's push/pop.
- `pk_pending` <= (next count != 0).
- Reset: head=tail=count=0, `last`=1 (producer 0 wins first tie), `pop_q`=0, underflow=0, `recv_data`=0, `pk_pending`=0; `reqN_ready` low (buffer logic idle, outputs combinational from reset state give ready=1 only after reset deasserts). Memory contents not reset. Reset mid-transfer discards all entries.
- Underflow cleared only by reset.

## Timing
- Push: word written on the accepting edge; visible at offset count-1 in `recv_data` one cycle after, if addressed.
- Pop: detected on the first edge after `recv_addr[7]` changes; `recv_data` reflects new head one edge later (2 edges from toggle). Nios must wait ≥2 cycles between toggles (always satisfied by PIO software rates); faster toggles within one cycle are lost.
- `pk_pending`: rises 1 edge after first accepted push; falls 1 edge after last pop.
- `recv_addr` assumed synchronous to `clk_clk` (same Qsys clock domain); no synchroniser.
- Throughput: 1 push/cycle sustained; alternation strict 1:1 while both valid.

## Test plan
- Reset: hold `reset_reset_n`=0 with all valids high -> `recv_data`=0, `pk_pending`=0, readys 0; release, addr 7'h7F -> status 32'h2000_0000.
- Single push: req0 sends 32'hCAFE_0001 -> req0_ready 1 cycle, next cycle `pk_pending`=1; addr 0 -> `recv_data`=32'hCAFE_0001; status count=1.
- Tie arbitration: both valid continuously, req0 words A0,A1, req1 words B0,B1 -> buffer order A0,B0,A1,B1 (peek offsets 0..3).
- Full: DEPTH=16, 17 pushes from req1 -> ready low on 17th, status [30]=1 count=16; one pop toggle -> 17th accepted next cycle, count stays 16.
- Simultaneous push/pop at count=5 -> count 5, head and tail both +1, offset 0 returns former entry 1.
- Underflow: empty buffer, toggle `recv_addr[7]` -> status 32'hA000_0000, `pk_pending` stays 0; persists after later pushes until reset.

Source files
------------

// File: rtl/recv_mailbox_arb_if.sv
// Producer handshakes and Nios PIO signals of the receive mailbox.
interface recv_mailbox_arb_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [7:0]  recv_addr;
  logic [31:0] recv_data;
  logic        pk_pending;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, recv_addr,
    input  req0_ready, req1_ready, recv_data, pk_pending
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, recv_addr,
    output req0_ready, req1_ready, recv_data, pk_pending
  );
endinterface

// File: rtl/recv_mailbox_arb.sv
// Two-producer round-robin receive mailbox: circular buffer pushed by
// producers, peeked/popped by the Nios through the recv_addr PIO.
module recv_mailbox_arb #(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  recv_mailbox_arb_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_last;
  logic          r_pop_q;
  logic          r_underflow;
  logic [31:0]   r_recv_data;
  logic          r_pk_pending;

  logic          w_full;
  logic          w_empty;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_rdy0;
  logic          w_rdy1;
  logic          w_push;
  logic [31:0]   w_push_data;
  logic          w_pop_req;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [6:0]    w_offset;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_mux;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // On a tie the requester that did not win last time is granted.
  assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);

  // Readies are held low while reset is asserted so nothing is accepted.
  assign w_rdy0 = w_gnt0 & ~w_full & reset_reset_n;
  assign w_rdy1 = w_gnt1 & ~w_full & reset_reset_n;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;

  assign w_push      = w_rdy0 | w_rdy1;
  assign w_push_data = w_rdy0 ? bus.req0_data : bus.req1_data;

  assign w_pop_req   = bus.recv_addr[7] ^ r_pop_q;
  assign w_pop       = w_pop_req & ~w_empty;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_offset = bus.recv_addr[6:0];
  assign w_rd_idx = r_head + w_offset[AW-1:0];
  assign w_status = {r_underflow, w_full, w_empty, 21'd0, 8'(r_count)};

  always_comb begin
    w_rd_mux = '0;
    if (w_offset == 7'h7F) begin
      w_rd_mux = w_status;
    end else if (8'(w_offset) < 8'(r_count)) begin
      w_rd_mux = r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_push_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_last       <= 1'b1;
      r_pop_q      <= 1'b0;
      r_underflow  <= 1'b0;
      r_recv_data  <= '0;
      r_pk_pending <= 1'b0;
    end else begin
      r_pop_q      <= bus.recv_addr[7];
      r_recv_data  <= w_rd_mux;
      r_count      <= w_count_nxt;
      r_pk_pending <= (w_count_nxt != '0);
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
        r_last <= w_rdy1;
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_pop_req && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.recv_data  = r_recv_data;
  assign bus.pk_pending = r_pk_pending;
endmodule
